// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce emulator and its LFSR.
package bounce_pkg;

    localparam int unsigned LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } bounce_state_t;

    // One right shift of a Galois LFSR with LFSR_TAPS feedback.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced so the register never locks at 0.
module lfsr16
    import bounce_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] reset_val;

    always_comb begin
        reset_val = (seed == '0) ? DEFAULT_SEED : seed;
        lfsr_d    = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= reset_val;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// Mechanical-contact emulator: turns each level change of clean_in into a
// pseudo-random burst of toggles on bouncy_out before settling at the new level.
module bounce_generator
    import bounce_pkg::*;
#(
    parameter int unsigned MIN_TOGGLES = 4,
    parameter logic [7:0]  TOGGLE_MASK = 8'h0F,
    parameter int unsigned GAP_W       = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clean_in,
    output logic bouncy_out,
    output logic stable_level,
    output logic busy
);

    localparam logic [GAP_W:0] GAP_ONE = (GAP_W + 1)'(1);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_unused;
    logic [8:0]        burst_len;
    logic [GAP_W:0]    gap_load;

    bounce_state_t     state_q, state_d;
    logic              bouncy_q, bouncy_d;
    logic              stable_q, stable_d;
    logic              busy_q, busy_d;
    logic              target_q, target_d;
    logic [8:0]        toggles_q, toggles_d;
    logic [GAP_W:0]    gap_q, gap_d;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .out  (lfsr)
    );

    assign lfsr_unused = lfsr;
    assign burst_len   = 9'(MIN_TOGGLES) + {1'b0, lfsr[7:0] & TOGGLE_MASK};
    assign gap_load    = {1'b0, lfsr[15 -: GAP_W]} + GAP_ONE;

    always_comb begin
        state_d   = state_q;
        bouncy_d  = bouncy_q;
        stable_d  = stable_q;
        busy_d    = busy_q;
        target_d  = target_q;
        toggles_d = toggles_q;
        gap_d     = gap_q;

        if (!ena) begin
            state_d   = S_IDLE;
            bouncy_d  = clean_in;
            stable_d  = clean_in;
            busy_d    = 1'b0;
            toggles_d = '0;
            gap_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    bouncy_d = stable_q;
                    busy_d   = 1'b0;
                    if (clean_in != stable_q) begin
                        // The starting edge is itself the first toggle of the burst.
                        target_d  = clean_in;
                        toggles_d = burst_len - 9'd1;
                        gap_d     = gap_load;
                        busy_d    = 1'b1;
                        bouncy_d  = ~stable_q;
                        state_d   = (burst_len == 9'd1) ? S_SETTLE : S_BOUNCE;
                    end
                end
                S_BOUNCE: begin
                    if (gap_q <= GAP_ONE) begin
                        bouncy_d  = ~bouncy_q;
                        toggles_d = toggles_q - 9'd1;
                        gap_d     = gap_load;
                        if (toggles_q <= 9'd1) begin
                            state_d = S_SETTLE;
                        end
                    end else begin
                        gap_d = gap_q - GAP_ONE;
                    end
                end
                S_SETTLE: begin
                    bouncy_d = target_q;
                    stable_d = target_q;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bouncy_q  <= 1'b0;
            stable_q  <= 1'b0;
            busy_q    <= 1'b0;
            target_q  <= 1'b0;
            toggles_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            bouncy_q  <= bouncy_d;
            stable_q  <= stable_d;
            busy_q    <= busy_d;
            target_q  <= target_d;
            toggles_q <= toggles_d;
            gap_q     <= gap_d;
        end
    end

    assign bouncy_out   = bouncy_q;
    assign stable_level = stable_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: two configurations driven in parallel, checked every
// cycle against a schedule-based model of the burst rules, plus literal pins.
module tb_bounce_generator;

    localparam int LFN = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b0;
    logic clean_in = 1'b0;
    logic [1:0] bouncy;
    logic [1:0] stable;
    logic [1:0] busy;

    int errors = 0;
    int checks = 0;

    bounce_generator #(
        .MIN_TOGGLES (4),
        .TOGGLE_MASK (8'h00),
        .GAP_W       (2),
        .SEED        (16'h1234)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .clean_in     (clean_in),
        .bouncy_out   (bouncy[0]),
        .stable_level (stable[0]),
        .busy         (busy[0])
    );

    bounce_generator #(
        .MIN_TOGGLES (4),
        .TOGGLE_MASK (8'h0F),
        .GAP_W       (4),
        .SEED        (16'h0000)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .clean_in     (clean_in),
        .bouncy_out   (bouncy[1]),
        .stable_level (stable[1]),
        .busy         (busy[1])
    );

    always #5 clk = ~clk;

    // Model configuration mirrors the parameter overrides above.
    int          min_t [2] = '{4, 4};
    int          mask_t[2] = '{0, 15};
    int          gapw  [2] = '{2, 4};
    logic [15:0] seed_t[2] = '{16'h1234, 16'h0000};

    // lf[d][k]: LFSR value seen at the k-th clock edge after reset release.
    logic [15:0] lf[2][LFN];

    logic m_bouncy[2] = '{1'b0, 1'b0};
    logic m_stable[2] = '{1'b0, 1'b0};
    logic m_busy  [2] = '{1'b0, 1'b0};
    logic m_active[2] = '{1'b0, 1'b0};
    logic m_target[2] = '{1'b0, 1'b0};
    int   m_n     [2] = '{0, 0};
    int   m_idx   [2] = '{0, 0};
    int   m_settle[2] = '{0, 0};
    int   sched   [2][512];
    int   k = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            lf[d][0] = (seed_t[d] == 16'h0000) ? 16'hACE1 : seed_t[d];
            for (int i = 1; i < LFN; i++)
                lf[d][i] = lf[d][i-1][0] ? ((lf[d][i-1] >> 1) ^ 16'hB400) : (lf[d][i-1] >> 1);
        end
    end

    function automatic int gap_of(input int d, input logic [15:0] l);
        return 1 + int'(l >> (16 - gapw[d]));
    endfunction

    // Toggle edges: start edge, then each following edge one gap (from the LFSR at the
    // previous toggle) later; settle is the edge right after the last toggle.
    task automatic plan(input int d, input int kk);
        int t;
        m_n[d] = min_t[d] + (int'(lf[d][kk][7:0]) & mask_t[d]);
        t = kk;
        for (int i = 0; i < m_n[d]; i++) begin
            sched[d][i] = t;
            if (t < LFN) t = t + gap_of(d, lf[d][t]);
        end
        m_settle[d] = sched[d][m_n[d]-1] + 1;
    endtask

    task automatic model_step(input int d, input int kk);
        if (!ena) begin
            m_bouncy[d] = clean_in;
            m_stable[d] = clean_in;
            m_busy[d]   = 1'b0;
            m_active[d] = 1'b0;
        end else if (m_active[d]) begin
            if (m_idx[d] < m_n[d]) begin
                if (sched[d][m_idx[d]] == kk) begin
                    m_bouncy[d] = ~m_bouncy[d];
                    m_idx[d]++;
                end
            end else if (kk == m_settle[d]) begin
                m_bouncy[d] = m_target[d];
                m_stable[d] = m_target[d];
                m_busy[d]   = 1'b0;
                m_active[d] = 1'b0;
            end
        end else if (clean_in != m_stable[d]) begin
            if (kk < LFN) plan(d, kk);
            m_target[d] = clean_in;
            m_bouncy[d] = ~m_bouncy[d];
            m_idx[d]    = 1;
            m_busy[d]   = 1'b1;
            m_active[d] = 1'b1;
        end else begin
            m_bouncy[d] = m_stable[d];
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            k = 0;
            for (int d = 0; d < 2; d++) begin
                m_bouncy[d] = 1'b0;
                m_stable[d] = 1'b0;
                m_busy[d]   = 1'b0;
                m_active[d] = 1'b0;
                m_idx[d]    = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) model_step(d, k);
            k = k + 1;
        end
    end

    task automatic check_bit(input string name, input int d, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d t=%0t got=%b exp=%b", name, d, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit("bouncy_out", d, bouncy[d], m_bouncy[d]);
            check_bit("stable_level", d, stable[d], m_stable[d]);
            check_bit("busy", d, busy[d], m_busy[d]);
        end
    end

    task automatic wait_idle(input int maxc);
        int quiet;
        quiet = 0;
        for (int c = 0; c < maxc && quiet < 3; c++) begin
            @(negedge clk);
            if (busy == 2'b00) quiet++;
            else quiet = 0;
        end
        check_int("idle_timeout", quiet, 3);
    endtask

    logic tr[2][2][120];

    task automatic run_trace(input int r);
        repeat (2) @(negedge clk);
        clean_in = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            tr[r][0][i] = bouncy[0];
            tr[r][1][i] = bouncy[1];
        end
    endtask

    initial begin
        int   edges;
        int   fall;
        int   diffs;
        logic prev;

        rst = 1'b0; ena = 1'b1; clean_in = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_bit("reset_bouncy", d, bouncy[d], 1'b0);
            check_bit("reset_stable", d, stable[d], 1'b0);
            check_bit("reset_busy", d, busy[d], 1'b0);
        end
        check_int("lf_b_1", int'(lf[1][1]), 32'hE270);
        check_int("lf_b_6", int'(lf[1][6]), 32'hB313);
        check_int("lf_a_2", int'(lf[0][2]), 32'h048D);

        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit("post_reset_bouncy", d, bouncy[d], 1'b0);
            check_bit("post_reset_busy", d, busy[d], 1'b0);
        end

        // dut_a first burst: gaps all 1 from seed 1234, toggles at edges 0..3, settle at 4.
        edges = 0; fall = -1; prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (bouncy[0] != prev) begin edges++; prev = bouncy[0]; end
            if (c == 0) begin
                check_bit("burst_start_busy", 0, busy[0], 1'b1);
                check_bit("burst_start_busy", 1, busy[1], 1'b1);
                check_int("model_n_a", m_n[0], 4);
                check_int("model_settle_a", m_settle[0], 4);
                check_int("model_n_b", m_n[1], 5);
            end
            if (c > 0 && !busy[0]) begin fall = c; break; end
        end
        check_int("first_burst_edges", edges, 5);
        check_int("first_burst_fall", fall, 4);
        check_bit("first_burst_stable", 0, stable[0], 1'b1);
        @(negedge clk);
        wait_idle(2000);
        check_bit("settle_stable", 1, stable[1], 1'b1);

        // Glitch back and forth while busy; target stays 1, no second burst.
        clean_in = 1'b0;
        wait_idle(2000);
        clean_in = 1'b1;
        @(negedge clk);
        clean_in = 1'b0;
        @(negedge clk);
        clean_in = 1'b1;
        wait_idle(2000);
        check_bit("glitch_target", 0, stable[0], 1'b1);
        check_bit("glitch_target", 1, stable[1], 1'b1);

        // Change held during a burst: first burst to 1, then a second to 0.
        clean_in = 1'b0;
        wait_idle(2000);
        clean_in = 1'b1;
        repeat (2) @(negedge clk);
        clean_in = 1'b0;
        wait_idle(2000);
        check_bit("second_burst", 0, stable[0], 1'b0);
        check_bit("second_burst", 1, stable[1], 1'b0);

        // Bypass, then ena rising with no difference, then ena dropped mid-burst.
        ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clean_in = ~clean_in;
            repeat (3) @(negedge clk);
        end
        ena = 1'b1;
        repeat (5) @(negedge clk);
        check_bit("ena_rise_no_burst", 0, busy[0], 1'b0);
        check_bit("ena_rise_no_burst", 1, busy[1], 1'b0);
        clean_in = ~clean_in;
        repeat (3) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check_bit("ena_drop_busy", 0, busy[0], 1'b0);
        check_bit("ena_drop_busy", 1, busy[1], 1'b0);
        ena = 1'b1;
        wait_idle(2000);

        // Reset mid-burst and repeat the same stimulus: identical edge timing.
        rst = 1'b0; clean_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_trace(0);
        clean_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_trace(1);
        for (int d = 0; d < 2; d++) begin
            diffs = 0;
            for (int i = 0; i < 120; i++)
                if (tr[0][d][i] !== tr[1][d][i]) diffs++;
            check_int(d == 0 ? "replay_a" : "replay_b", diffs, 0);
        end
        wait_idle(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
Synthesizable emulator of a mechanical contact: converts a clean level (`clean_in`) into a bouncy waveform (`bouncy_out`). On each level change it produces a burst of pseudo-random toggles before settling at the new level. It is the driving end for the debouncer in hardware-in-loop and self-test builds, and the bench uses it as a repeatable stimulus source. Randomness comes from an on-chip 16-bit LFSR, so every run is deterministic for a given seed.

Parameters:
MIN_TOGGLES, 4, minimum number of glitch toggles per transition (1..255).
TOGGLE_MASK, 8'h0F, AND-mask on LFSR bits [7:0]; extra toggles = lfsr[7:0] & TOGGLE_MASK.
GAP_W, 4, width of the gap field; gap between toggles = 1 + lfsr[15:16-GAP_W] cycles (1..2^GAP_W).
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-low.
ena  input  1  1 = bounce emulation; 0 = bypass (`bouncy_out` follows `clean_in` with 1-cycle latency).
clean_in  input  1  ideal switch level (already synchronous to `clk`).
bouncy_out  output  1  emulated contact output, registered.
stable_level  output  1  last settled level; the scoreboard reference.
busy  output  1  high from burst start until settle completes.

Behaviour:
- Reset (`rst`=0, async) values:
  - `bouncy_out`=0, `stable_level`=0, `busy`=0.
  - state=S_IDLE.
  - LFSR=SEED (or 16'hACE1 if SEED=0).
  - toggle counter and gap counter = 0.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shifts right every cycle after reset, independent of state.
  - Never reaches 0.
- S_IDLE:
  - `bouncy_out`=`stable_level`, `busy`=0.
  - If `ena` && `clean_in`!=`stable_level`: capture target=`clean_in`.
  - Load toggles_left = MIN_TOGGLES + (lfsr[7:0] & TOGGLE_MASK), 9-bit, no overflow.
  - Load gap from the current LFSR value.
  - Set `busy`=1 and go to S_BOUNCE next cycle.
  - `bouncy_out` toggles on that same edge; this is the first toggle and counts toward toggles_left.
- S_BOUNCE:
  - Gap counter decrements each cycle.
  - When it reaches 0: toggle `bouncy_out`, decrement toggles_left, reload gap from the current LFSR value.
  - When toggles_left reaches 0, go to S_SETTLE.
- S_SETTLE:
  - Drive `bouncy_out`=target on the first cycle.
  - Update `stable_level`=target and go to S_IDLE; `busy` falls on the same edge.
  - Consequence: the final level always equals target regardless of toggle parity.
  - Total `bouncy_out` edges per transition = N or N+1, where N is the loaded toggle count.
- `clean_in` changes while `busy`:
  - Ignored; target is not re-sampled.
  - After returning to S_IDLE, a still-differing `clean_in` starts a new burst on the next cycle.
- `ena`=0:
  - Any state returns to S_IDLE next cycle.
  - `bouncy_out` <= `clean_in` and `stable_level` <= `clean_in` each cycle; `busy`=0.
  - Toggle and gap counters are cleared.
  - `ena` rising with `clean_in`==`stable_level` starts no burst.
- Reset mid-burst:
  - Immediate return to reset values.
  - LFSR reloads SEED, so the sequence after reset repeats exactly.
- Widths:
  - Toggle counter 9 bits.
  - Gap counter GAP_W+1 bits, holding 1..2^GAP_W.

Decomposition:
- Package `bounce_pkg`:
  - `bounce_state_t` enum {S_IDLE, S_BOUNCE, S_SETTLE}.
  - LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1, LFSR_W=16.
- One sub-module: `lfsr16` (clk, rst, seed, out[15:0]), shared with future random stimulus blocks.

Test Plan:
- Reset with `clean_in`=1, `ena`=1 -> during and 1 cycle after reset: `bouncy_out`=0, `stable_level`=0, `busy`=0. Next cycle a burst starts (`busy`=1).
- TOGGLE_MASK=0, MIN_TOGGLES=4, GAP_W=2, `clean_in` 0->1 -> exactly 4 toggles, each 1..4 cycles apart, then `bouncy_out`=1 steady. `stable_level`=1 and `busy`=0 at settle. The bench model of `lfsr16` predicts every edge time exactly.
- `clean_in` 1->0 mid-burst, then back to 1 before settle -> burst completes to target 1. No second burst starts because `clean_in`==`stable_level`.
- `clean_in` 0->1, then 1->0 mid-burst, held -> first burst settles at 1. Next cycle a second burst starts and settles at 0.
- `ena`=0 with `clean_in` toggling every 3 cycles -> `bouncy_out` equals `clean_in` delayed 1 cycle, `busy`=0. Drop `ena` mid-burst -> `busy`=0 next cycle.
- Assert `rst` mid-burst, release, repeat the identical stimulus -> the `bouncy_out` edge timing matches the first run cycle-for-cycle (seed reload).
